// File: rtl/wb_periph_pkg.sv
// Shared types and constants for the Wishbone peripheral decoder.
// The optional ack timeout is enabled with WB_PERIPH_DECODER_TIMEOUT_EN.
package wb_periph_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  // Address bits [19:12] that identify the peripheral window
  localparam logic [7:0] PERIPH_REGION = 8'hE0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLAVE = 2'd1,
    DFLT  = 2'd2,
    TOUT  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_periph_addr_decode.sv
// Combinational decode of address bits [19:8] into a one-hot slave select.
// Slave i owns the 256-byte page i inside the peripheral region.
module wb_periph_addr_decode
  import wb_periph_pkg::*;
#(
  parameter int NUM_SLAVES = 2
) (
  input  logic [19:8]           adr,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic                  valid
);

  logic region_hit;

  assign region_hit = (adr[19:12] == PERIPH_REGION);

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign onehot[gi] = region_hit && (adr[11:8] == 4'(gi));
  end

  assign valid = |onehot;

endmodule

// File: rtl/wb_periph_decoder.sv
// Wishbone master-to-peripheral decoder with a default responder for unmapped addresses.
// Define WB_PERIPH_DECODER_TIMEOUT_EN to add the slave-ack timeout and error counter.
module wb_periph_decoder
  import wb_periph_pkg::*;
#(
  parameter int                NUM_SLAVES     = 2,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA  = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wbm_cyc_i,
  input  logic                         wbm_stb_i,
  input  logic                         wbm_we_i,
  input  logic [3:0]                   wbm_sel_i,
  input  logic [ADDR_W-1:0]            wbm_adr_i,
  input  logic [DATA_W-1:0]            wbm_dat_i,
  output logic                         wbm_ack_o,
  output logic                         wbm_err_o,
  output logic [DATA_W-1:0]            wbm_dat_o,
  output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]        wbs_stb_o,
  output logic                         wbs_we_o,
  output logic [3:0]                   wbs_sel_o,
  output logic [ADDR_W-1:0]            wbs_adr_o,
  output logic [DATA_W-1:0]            wbs_dat_o,
  input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
  input  logic [DATA_W*NUM_SLAVES-1:0] wbs_dat_i,
  output logic [7:0]                   timeout_cnt_o
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("wb_periph_decoder: NUM_SLAVES or TIMEOUT_CYCLES out of range");
  end

  state_t                  state_reg;
  logic [NUM_SLAVES-1:0]   sel_reg;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    dec_valid;
  logic                    req;
  logic                    slave_ack;
  logic                    dflt_ack;
  logic [DATA_W-1:0]       slave_rdata;

  wb_periph_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_addr_decode (
    .adr    (wbm_adr_i[19:8]),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  assign req = wbm_cyc_i & wbm_stb_i;

  // Strobes follow the state register, so an async reset or a master abort removes them at once
  assign wbs_cyc_o = (state_reg == SLAVE && wbm_cyc_i) ? sel_reg : '0;
  assign wbs_stb_o = (state_reg == SLAVE && wbm_cyc_i) ? sel_reg : '0;

  assign slave_ack = (state_reg == SLAVE) && wbm_cyc_i && (|(wbs_ack_i & sel_reg));
  assign dflt_ack  = (state_reg == DFLT) && wbm_cyc_i;

  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg[i]) slave_rdata = slave_rdata | wbs_dat_i[DATA_W*i +: DATA_W];
    end
  end

  assign wbm_ack_o = slave_ack | dflt_ack;
  assign wbm_dat_o = slave_ack ? slave_rdata :
                     dflt_ack  ? DEFAULT_RDATA : '0;

`ifdef WB_PERIPH_DECODER_TIMEOUT_EN
  localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt_reg;
  logic [7:0] tout_cnt_reg;

  assign wbm_err_o     = (state_reg == TOUT);
  assign timeout_cnt_o = tout_cnt_reg;
`else
  assign wbm_err_o     = 1'b0;
  assign timeout_cnt_o = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      wbs_we_o  <= 1'b0;
      wbs_sel_o <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
`ifdef WB_PERIPH_DECODER_TIMEOUT_EN
      wait_cnt_reg <= '0;
      tout_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
`ifdef WB_PERIPH_DECODER_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
          if (req) begin
            wbs_we_o  <= wbm_we_i;
            wbs_sel_o <= wbm_sel_i;
            wbs_adr_o <= wbm_adr_i;
            wbs_dat_o <= wbm_dat_i;
            sel_reg   <= dec_onehot;
            state_reg <= dec_valid ? SLAVE : DFLT;
          end
        end
        SLAVE: begin
          // An ack on the last counted cycle takes priority over the timeout
          if (!wbm_cyc_i || slave_ack) state_reg <= IDLE;
`ifdef WB_PERIPH_DECODER_TIMEOUT_EN
          else if (wait_cnt_reg == TOUT_LAST) state_reg <= TOUT;
          else wait_cnt_reg <= wait_cnt_reg + 8'd1;
`endif
        end
        DFLT: state_reg <= IDLE;
`ifdef WB_PERIPH_DECODER_TIMEOUT_EN
        TOUT: begin
          if (tout_cnt_reg != 8'hFF) tout_cnt_reg <= tout_cnt_reg + 8'd1;
          state_reg <= IDLE;
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_periph_decoder.sv
// Directed-vector bench for wb_periph_decoder with two behavioural slaves.
// Timeout checks are compiled in when WB_PERIPH_DECODER_TIMEOUT_EN is defined.
module tb_wb_periph_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_w = 32'h0;
  logic        ack, err;
  logic [31:0] rdat;
  logic [1:0]  s_cyc, s_stb, s_ack;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic [63:0] s_rdat;
  logic [7:0]  tcnt;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_periph_decoder #(
    .NUM_SLAVES     (2),
    .TIMEOUT_CYCLES (8),
    .DEFAULT_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wbm_cyc_i     (cyc),
    .wbm_stb_i     (stb),
    .wbm_we_i      (we),
    .wbm_sel_i     (sel),
    .wbm_adr_i     (adr),
    .wbm_dat_i     (dat_w),
    .wbm_ack_o     (ack),
    .wbm_err_o     (err),
    .wbm_dat_o     (rdat),
    .wbs_cyc_o     (s_cyc),
    .wbs_stb_o     (s_stb),
    .wbs_we_o      (s_we),
    .wbs_sel_o     (s_sel),
    .wbs_adr_o     (s_adr),
    .wbs_dat_o     (s_dat),
    .wbs_ack_i     (s_ack),
    .wbs_dat_i     (s_rdat),
    .timeout_cnt_o (tcnt)
  );

  // Behavioural slaves: ack once the strobe has been high for s_lat[i] earlier cycles
  logic [1:0]  s_en = 2'b00;
  logic [1:0]  extra_ack = 2'b00;
  int          s_lat[2];
  logic [31:0] s_data[2];
  int          s_cnt[2];

  initial begin
    s_lat[0] = 0; s_lat[1] = 0;
    s_data[0] = 32'h0; s_data[1] = 32'h0;
    s_cnt[0] = 0; s_cnt[1] = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      s_cnt[i] <= (s_stb[i] && !s_ack[i]) ? s_cnt[i] + 1 : 0;
  end

  always_comb begin
    s_ack = 2'b00;
    for (int i = 0; i < 2; i++)
      s_ack[i] = extra_ack[i] | (s_en[i] & s_stb[i] & (s_cnt[i] >= s_lat[i]));
  end

  assign s_rdat = {s_data[1], s_data[0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input int max_cyc,
                          output int lat, output logic [31:0] rd,
                          output logic got_ack, output logic got_err,
                          output logic [1:0] stb_or, output logic [1:0] stb_end,
                          output logic [31:0] snap_adr, output logic [31:0] snap_dat,
                          output logic snap_we, output logic [3:0] snap_sel);
    logic snapped;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_w = d; sel = s;
    lat = 0; rd = 32'h0; got_ack = 1'b0; got_err = 1'b0; stb_or = 2'b00; stb_end = 2'b00;
    snap_adr = 32'h0; snap_dat = 32'h0; snap_we = 1'b0; snap_sel = 4'h0; snapped = 1'b0;
    while (!got_ack && !got_err && lat < max_cyc) begin
      @(negedge clk);
      lat++;
      stb_or = stb_or | s_stb;
      if (s_stb != 2'b00 && !snapped) begin
        snap_adr = s_adr; snap_dat = s_dat; snap_we = s_we; snap_sel = s_sel;
        snapped = 1'b1;
      end
      if (ack || err) begin
        got_ack = ack; got_err = err; rd = rdat; stb_end = s_stb;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wd;
    logic [3:0]  sel;
    int          lat0;
    int          lat1;
    logic [31:0] sd0;
    logic [31:0] sd1;
    logic [1:0]  exp_stb;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  int          lat;
  logic [31:0] rd, snap_adr, snap_dat;
  logic        got_ack, got_err, snap_we;
  logic [1:0]  stb_or, stb_end;
  logic [3:0]  snap_sel;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int errs;

    vecs[0] = '{32'h000E0004, 1'b0, 32'h0,        4'hF, 1, 0, 32'h12345678, 32'h0BADF00D, 2'b01, 3, 32'h12345678};
    vecs[1] = '{32'h000E0100, 1'b1, 32'hA5A5A5A5, 4'hF, 0, 2, 32'h12345678, 32'h0BADF00D, 2'b10, 4, 32'h0BADF00D};
    vecs[2] = '{32'h00001000, 1'b0, 32'h0,        4'hF, 0, 0, 32'h11111111, 32'h22222222, 2'b00, 2, 32'hDEADBEEF};
    vecs[3] = '{32'h000E0200, 1'b0, 32'h0,        4'hF, 0, 0, 32'h11111111, 32'h22222222, 2'b00, 2, 32'hDEADBEEF};
    vecs[4] = '{32'h001E0000, 1'b0, 32'h0,        4'h3, 0, 0, 32'hCAFE0001, 32'h22222222, 2'b01, 2, 32'hCAFE0001};
    vecs[5] = '{32'h000F0000, 1'b0, 32'h0,        4'hF, 0, 0, 32'h11111111, 32'h22222222, 2'b00, 2, 32'hDEADBEEF};
    vecs[6] = '{32'h000E0101, 1'b0, 32'h0,        4'hF, 0, 0, 32'h11111111, 32'h55AA33CC, 2'b10, 2, 32'h55AA33CC};
    vecs[7] = '{32'h000D0000, 1'b1, 32'h11112222, 4'h1, 0, 0, 32'h11111111, 32'h22222222, 2'b00, 2, 32'hDEADBEEF};

    // Reset state with a live request on the bus
    cyc = 1'b1; stb = 1'b1; adr = 32'h000E0000; we = 1'b1; dat_w = 32'hFFFFFFFF; sel = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_stb", {30'h0, s_stb}, 32'h0);
    check("rst_cyc", {30'h0, s_cyc}, 32'h0);
    check("rst_adr", s_adr, 32'h0);
    check("rst_dat", s_dat, 32'h0);
    check("rst_we_sel", {27'h0, s_we, s_sel}, 32'h0);
    check("rst_ack_err", {30'h0, ack, err}, 32'h0);
    check("rst_rdat", rdat, 32'h0);
    check("rst_tcnt", {24'h0, tcnt}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    rst = 1'b0;

    s_en = 2'b11;
    for (int v = 0; v < 8; v++) begin
      s_lat[0] = vecs[v].lat0; s_lat[1] = vecs[v].lat1;
      s_data[0] = vecs[v].sd0; s_data[1] = vecs[v].sd1;
      run_xfer(vecs[v].adr, vecs[v].we, vecs[v].wd, vecs[v].sel, 50,
               lat, rd, got_ack, got_err, stb_or, stb_end, snap_adr, snap_dat, snap_we, snap_sel);
      check($sformatf("v%0d_ack_err", v), {30'h0, got_ack, got_err}, 32'h2);
      check($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rd);
      check($sformatf("v%0d_stb_seen", v), {30'h0, stb_or}, {30'h0, vecs[v].exp_stb});
      check($sformatf("v%0d_stb_at_ack", v), {30'h0, stb_end}, {30'h0, vecs[v].exp_stb});
      if (vecs[v].exp_stb != 2'b00) begin
        check($sformatf("v%0d_s_adr", v), snap_adr, vecs[v].adr);
        check($sformatf("v%0d_s_dat", v), snap_dat, vecs[v].wd);
        check($sformatf("v%0d_s_we_sel", v), {27'h0, snap_we, snap_sel}, {27'h0, vecs[v].we, vecs[v].sel});
      end
      @(negedge clk);
      check($sformatf("v%0d_after_stb", v), {30'h0, s_stb}, 32'h0);
      check($sformatf("v%0d_after_ack", v), {31'h0, ack}, 32'h0);
      check($sformatf("v%0d_after_rdat", v), rdat, 32'h0);
      $display("vec %0d adr=%h we=%b lat=%0d rd=%h stb=%b", v, vecs[v].adr, vecs[v].we, lat, rd, stb_or);
    end

    // Foreign ack ignored, then master abort mid-SLAVE
    s_en = 2'b00;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h000E0000; we = 1'b0; sel = 4'hF;
    repeat (3) @(negedge clk);
    check("ign_stb0", {30'h0, s_stb}, 32'h1);
    extra_ack = 2'b10;
    #1;
    check("ign_ack", {30'h0, ack, err}, 32'h0);
    check("ign_rdat", rdat, 32'h0);
    extra_ack = 2'b00;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    #1;
    check("abort_now_cyc", {30'h0, s_cyc}, 32'h0);
    check("abort_now_ack", {30'h0, ack, err}, 32'h0);
    @(negedge clk);
    check("abort_next_cyc", {30'h0, s_cyc}, 32'h0);
    check("abort_next_ack", {30'h0, ack, err}, 32'h0);
    run_xfer(32'h00002000, 1'b0, 32'h0, 4'hF, 50,
             lat, rd, got_ack, got_err, stb_or, stb_end, snap_adr, snap_dat, snap_we, snap_sel);
    check("abort_then_lat", 32'(lat), 32'd2);
    check("abort_then_rd", rd, 32'hDEADBEEF);
    $display("abort seq lat=%0d rd=%h", lat, rd);

    // Master holds strobe across acks: one fresh transfer per two cycles
    s_en = 2'b01; s_lat[0] = 0; s_data[0] = 32'h0F0F0F0F;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h000E0000;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) acks++;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    check("held_stb_acks", 32'(acks), 32'd3);
    $display("held stb acks=%0d", acks);

    // Asynchronous reset in SLAVE, then a clean read
    s_en = 2'b00;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h000E0000; we = 1'b1; dat_w = 32'h77777777; sel = 4'hF;
    repeat (2) @(negedge clk);
    check("rstmid_pre_stb", {30'h0, s_stb}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_stb", {30'h0, s_stb, s_cyc}, 32'h0);
    check("rstmid_adr", s_adr, 32'h0);
    check("rstmid_dat", s_dat, 32'h0);
    check("rstmid_we", {31'h0, s_we}, 32'h0);
    check("rstmid_ack", {30'h0, ack, err}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    s_en = 2'b01; s_lat[0] = 0; s_data[0] = 32'h13579BDF;
    run_xfer(32'h000E0000, 1'b0, 32'h0, 4'hF, 50,
             lat, rd, got_ack, got_err, stb_or, stb_end, snap_adr, snap_dat, snap_we, snap_sel);
    check("rstmid_then_ack", {30'h0, got_ack, got_err}, 32'h2);
    check("rstmid_then_lat", 32'(lat), 32'd2);
    check("rstmid_then_rd", rd, 32'h13579BDF);
    $display("reset-mid seq lat=%0d rd=%h", lat, rd);

`ifdef WB_PERIPH_DECODER_TIMEOUT_EN
    // Silent slave: error after 8 SLAVE cycles
    s_en = 2'b00;
    run_xfer(32'h000E0000, 1'b0, 32'h0, 4'hF, 50,
             lat, rd, got_ack, got_err, stb_or, stb_end, snap_adr, snap_dat, snap_we, snap_sel);
    check("tout_ack_err", {30'h0, got_ack, got_err}, 32'h1);
    check("tout_lat", 32'(lat), 32'd10);
    check("tout_rdat", rd, 32'h0);
    check("tout_stb", {30'h0, stb_end}, 32'h0);
    @(negedge clk);
    check("tout_err_pulse", {31'h0, err}, 32'h0);
    check("tout_cnt1", {24'h0, tcnt}, 32'd1);
    $display("timeout lat=%0d tcnt=%0d", lat, tcnt);

    // Ack on the eighth SLAVE cycle beats the timeout
    s_en = 2'b01; s_lat[0] = 7; s_data[0] = 32'h600DF00D;
    run_xfer(32'h000E0000, 1'b0, 32'h0, 4'hF, 50,
             lat, rd, got_ack, got_err, stb_or, stb_end, snap_adr, snap_dat, snap_we, snap_sel);
    check("lastack_ack_err", {30'h0, got_ack, got_err}, 32'h2);
    check("lastack_lat", 32'(lat), 32'd9);
    check("lastack_rd", rd, 32'h600DF00D);
    @(negedge clk);
    check("lastack_tcnt", {24'h0, tcnt}, 32'd1);
    $display("last-cycle ack lat=%0d rd=%h", lat, rd);

    s_en = 2'b00;
    errs = 0;
    for (int k = 0; k < 299; k++) begin
      run_xfer(32'h000E0100, 1'b0, 32'h0, 4'hF, 50,
               lat, rd, got_ack, got_err, stb_or, stb_end, snap_adr, snap_dat, snap_we, snap_sel);
      if (got_err) errs++;
    end
    @(negedge clk);
    check("sat_errs", 32'(errs), 32'd299);
    check("sat_tcnt", {24'h0, tcnt}, 32'd255);
    $display("saturation errs=%0d tcnt=%0d", errs, tcnt);
`else
    // Without the timeout a silent slave is waited on indefinitely
    s_en = 2'b00; s_lat[0] = 0; s_data[0] = 32'h2468ACE0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h000E0000; we = 1'b0;
    errs = 0; acks = 0;
    repeat (300) begin
      @(negedge clk);
      if (err) errs++;
      if (ack) acks++;
    end
    check("noto_errs", 32'(errs), 32'd0);
    check("noto_acks", 32'(acks), 32'd0);
    check("noto_stb", {30'h0, s_stb}, 32'h1);
    check("noto_tcnt", {24'h0, tcnt}, 32'd0);
    s_en = 2'b01;
    #1;
    check("noto_late_ack", {30'h0, ack, err}, 32'h2);
    check("noto_late_rd", rdat, 32'h2468ACE0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    $display("no-timeout wait errs=%0d acks=%0d", errs, acks);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
